sysio_ctrl: RTL and testbench
=============================

Name: sysio_ctrl

Overview:
- Parametrised system I/O controller for the 68000 side; successor to the discrete latch/mux I/O logic.
- Holds the control and priority latches, sound-command latch with Z80 handshake, VBLANK interrupt latch, watchdog, and the input read mux.
- All logic is synchronous to clk_main. It replaces the edge-clocked latches and the async LS74 with clocked edge detection.
- Sits between the CPU address decode and the video/sound subsystems.

Parameters:
- NUM_PLAYERS, 4, number of 8-bit player input ports (1..6).
- WDOG_BITS, 20, watchdog counter width; timeout after 2^WDOG_BITS-1 cycles without a kick.
- WDOG_PULSE, 16, length of the watchdog reset pulse in cycles (1..255).

Ports:
- clk_main  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- io_we  in  1  one-cycle write strobe.
- io_re  in  1  one-cycle read strobe.
- io_addr  in  4  register address.
- io_din  in  8  write data (CPU low byte).
- io_dout  out  8  read data, registered.
- p_in  in  8*NUM_PLAYERS  player inputs, active-low; player n at bits [8n+7:8n].
- coin  in  4  active-low coin inputs.
- service  in  4  active-low service inputs.
- dip1, dip2  in  8  DIP banks.
- dip3  in  4  DIP bank 3.
- nvblk  in  1  active-low vertical blank from the video timing block.
- ipl_n  out  1  interrupt request to CPU (drives IPL2/IPL0), active-low.
- rmrd, int_en, snd_on  out  1  control latch bits.
- coin_counter  out  2  coin meter drives.
- pri  out  2  priority select {PRI2, PRI}.
- snd_cmd  out  8  sound command byte to the Z80.
- snd_irq  out  1  high while a command is pending for the Z80.
- snd_ack  in  1  one-cycle pulse; the Z80 has read snd_cmd.
- wdog_rst  out  1  watchdog reset request, active-high.

Behaviour:
- Reset values:
  - io_dout, snd_cmd, pri, coin_counter: 0.
  - rmrd, int_en, snd_on, snd_irq, wdog_rst, overrun: 0.
  - ipl_n: 1; watchdog counter: 0.
- Writes, taking effect on the clock edge where io_we=1:
  - addr 0, control: rmrd<=din[7], int_en<=din[5], snd_on<=din[3], coin_counter<=din[1:0].
  - addr 1, sound command: snd_cmd<=din, snd_irq<=1. If snd_irq was already 1 and snd_ack is not also asserted in that cycle, set overrun<=1 (sticky); the new byte overwrites the old one.
  - addr 2, watchdog kick: counter<=0. Data is ignored.
  - addr 3, priority: pri<=din[3:2].
  - addr 11: clear overrun.
  - Other addresses: ignored.
- Reads: io_dout is loaded on the edge where io_re=1 (1-cycle latency) and holds its value otherwise.
  - addr 0: {service, coin}.
  - addr 1..NUM_PLAYERS: p_in byte addr-1.
  - addr 8: dip1. addr 9: dip2. addr 10: {4'h0, dip3}.
  - addr 11: {6'b0, overrun, snd_irq}.
  - All other addresses: 8'hFF.
- Simultaneous io_we and io_re: both act; read data reflects the pre-write state.
- Sound handshake:
  - snd_ack sets snd_irq<=0.
  - A write and snd_ack in the same cycle: the write wins, so snd_irq=1 and overrun is unchanged.
- VBLANK interrupt:
  - nvblk is sampled through a 2-flop synchroniser and a falling edge is detected (blank start).
  - On the detected edge with int_en=1, ipl_n<=0.
  - int_en=0 forces ipl_n<=1 on the next edge. A clear has priority over a same-cycle set.
  - ipl_n stays low until int_en is written 0. Software acks by toggling int_en.
- Watchdog:
  - The counter increments every cycle while wdog_rst=0.
  - When the counter reaches all-ones, wdog_rst<=1 for exactly WDOG_PULSE cycles, then the counter is cleared and counting resumes.
  - A kick during the pulse is ignored.
  - wdog_rst does not reset this block; it is consumed externally.
- Reset mid-operation clears every state immediately, including a pending snd_irq and an active wdog_rst.

Optional Feature:
- INPUT_SYNC_EN defined:
  - p_in, coin and service pass through 2-flop synchronisers before the read mux.
  - A change in an input becomes visible to reads 2 cycles later.
  - The synchroniser flops reset to all-ones (inputs released).
- INPUT_SYNC_EN undefined: the read mux samples the raw inputs directly, with 0-cycle input-to-read visibility.

Test Plan:
- Reset, then read addr 11, addr 0 and addr 12 with all inputs high → io_dout = 8'h00, 8'hFF, 8'hFF; ipl_n=1; wdog_rst=0.
- Write addr 0 = 8'hAB, then write addr 3 = 8'h0C → rmrd=1, int_en=1, snd_on=1, coin_counter=2'b11, pri=2'b11.
- Write addr 1 = 8'h5A, then addr 1 = 8'h33 with no ack, then read addr 11 → snd_cmd=8'h33, snd_irq=1, read 8'h03. Pulse snd_ack, write addr 11, read addr 11 → 8'h00.
- int_en=1, then drive nvblk 1→0 → ipl_n=0 within 3 cycles. Write addr 0 with bit5=0 → ipl_n=1 the next cycle. With int_en=0, an nvblk fall keeps ipl_n=1.
- WDOG_BITS=4, WDOG_PULSE=3, no kicks → wdog_rst high for exactly 3 cycles starting at cycle 15 after reset, repeating. Kicking every 10 cycles → wdog_rst never asserts.
- NUM_PLAYERS=2, p_in=16'h7EFD → addr 1 reads 8'hFD, addr 2 reads 8'h7E, addr 3 reads 8'hFF. With INPUT_SYNC_EN, a p_in change is visible to reads after 2 cycles.

Source files
------------

// File: rtl/sysio_ctrl.sv
// 68000-side system I/O controller: control/priority latches, sound-command handshake, VBLANK IRQ,
// watchdog and input read mux. Define INPUT_SYNC_EN to add 2-flop synchronisers on p_in/coin/service.
module sysio_ctrl #(
  parameter int unsigned NUM_PLAYERS = 4,
  parameter int unsigned WDOG_BITS   = 20,
  parameter int unsigned WDOG_PULSE  = 16
) (
  input  logic                     clk_main,
  input  logic                     reset,
  input  logic                     io_we,
  input  logic                     io_re,
  input  logic [3:0]               io_addr,
  input  logic [7:0]               io_din,
  output logic [7:0]               io_dout,
  input  logic [8*NUM_PLAYERS-1:0] p_in,
  input  logic [3:0]               coin,
  input  logic [3:0]               service,
  input  logic [7:0]               dip1,
  input  logic [7:0]               dip2,
  input  logic [3:0]               dip3,
  input  logic                     nvblk,
  output logic                     ipl_n,
  output logic                     rmrd,
  output logic                     int_en,
  output logic                     snd_on,
  output logic [1:0]               coin_counter,
  output logic [1:0]               pri,
  output logic [7:0]               snd_cmd,
  output logic                     snd_irq,
  input  logic                     snd_ack,
  output logic                     wdog_rst
);

  localparam logic [7:0] PulseLast = 8'(WDOG_PULSE - 1);

  logic [7:0]           io_dout_q, io_dout_d;
  logic [7:0]           snd_cmd_q, snd_cmd_d;
  logic [1:0]           pri_q, pri_d;
  logic [1:0]           cc_q, cc_d;
  logic                 rmrd_q, rmrd_d;
  logic                 int_en_q, int_en_d;
  logic                 snd_on_q, snd_on_d;
  logic                 snd_irq_q, snd_irq_d;
  logic                 ovr_q, ovr_d;
  logic                 ipl_n_q, ipl_n_d;
  logic                 wdog_rst_q, wdog_rst_d;
  logic [WDOG_BITS-1:0] wdog_cnt_q, wdog_cnt_d;
  logic [7:0]           pulse_q, pulse_d;
  logic [2:0]           vb_q;

  logic [8*NUM_PLAYERS-1:0] p_src;
  logic [3:0]               coin_src, service_src;

`ifdef INPUT_SYNC_EN
  logic [8*NUM_PLAYERS-1:0] p_s1_q, p_s2_q;
  logic [3:0]               coin_s1_q, coin_s2_q, svc_s1_q, svc_s2_q;

  // Reset to all-ones so released inputs read as inactive straight out of reset.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      p_s1_q    <= '1;
      p_s2_q    <= '1;
      coin_s1_q <= '1;
      coin_s2_q <= '1;
      svc_s1_q  <= '1;
      svc_s2_q  <= '1;
    end else begin
      p_s1_q    <= p_in;
      p_s2_q    <= p_s1_q;
      coin_s1_q <= coin;
      coin_s2_q <= coin_s1_q;
      svc_s1_q  <= service;
      svc_s2_q  <= svc_s1_q;
    end
  end

  assign p_src       = p_s2_q;
  assign coin_src    = coin_s2_q;
  assign service_src = svc_s2_q;
`else
  assign p_src       = p_in;
  assign coin_src    = coin;
  assign service_src = service;
`endif

  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'hFF;
    case (io_addr)
      4'd0:    rd_data = {service_src, coin_src};
      4'd8:    rd_data = dip1;
      4'd9:    rd_data = dip2;
      4'd10:   rd_data = {4'h0, dip3};
      4'd11:   rd_data = {6'b0, ovr_q, snd_irq_q};
      default: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (io_addr == 4'(i + 1)) rd_data = p_src[8*i +: 8];
        end
      end
    endcase
  end

  logic snd_wr, kick, ovr_clr, vb_fall;

  assign snd_wr  = io_we && (io_addr == 4'd1);
  assign kick    = io_we && (io_addr == 4'd2);
  assign ovr_clr = io_we && (io_addr == 4'd11);
  // vb_q[1] is the synchronised nvblk, vb_q[2] its previous value.
  assign vb_fall = vb_q[2] && !vb_q[1];

  always_comb begin
    io_dout_d  = io_dout_q;
    snd_cmd_d  = snd_cmd_q;
    pri_d      = pri_q;
    cc_d       = cc_q;
    rmrd_d     = rmrd_q;
    int_en_d   = int_en_q;
    snd_on_d   = snd_on_q;
    snd_irq_d  = snd_irq_q;
    ovr_d      = ovr_q;
    ipl_n_d    = ipl_n_q;
    wdog_rst_d = wdog_rst_q;
    wdog_cnt_d = wdog_cnt_q;
    pulse_d    = pulse_q;

    if (io_re) io_dout_d = rd_data;

    if (io_we) begin
      case (io_addr)
        4'd0: begin
          rmrd_d   = io_din[7];
          int_en_d = io_din[5];
          snd_on_d = io_din[3];
          cc_d     = io_din[1:0];
        end
        4'd1:    snd_cmd_d = io_din;
        4'd3:    pri_d     = io_din[3:2];
        default: ;
      endcase
    end

    // A CPU write beats a same-cycle Z80 ack; overwriting an unread command flags overrun.
    if (snd_wr) begin
      snd_irq_d = 1'b1;
      if (snd_irq_q && !snd_ack) ovr_d = 1'b1;
    end else if (snd_ack) begin
      snd_irq_d = 1'b0;
    end
    if (ovr_clr) ovr_d = 1'b0;

    if (!int_en_q)    ipl_n_d = 1'b1;
    else if (vb_fall) ipl_n_d = 1'b0;

    // Counter parks at all-ones during the pulse; kicks are ignored until it ends.
    if (wdog_rst_q) begin
      if (pulse_q == 8'd0) begin
        wdog_rst_d = 1'b0;
        wdog_cnt_d = '0;
      end else begin
        pulse_d = pulse_q - 8'd1;
      end
    end else if (kick) begin
      wdog_cnt_d = '0;
    end else begin
      wdog_cnt_d = wdog_cnt_q + WDOG_BITS'(1);
      if (wdog_cnt_d == '1) begin
        wdog_rst_d = 1'b1;
        pulse_d    = PulseLast;
      end
    end
  end

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      io_dout_q  <= 8'h00;
      snd_cmd_q  <= 8'h00;
      pri_q      <= 2'b00;
      cc_q       <= 2'b00;
      rmrd_q     <= 1'b0;
      int_en_q   <= 1'b0;
      snd_on_q   <= 1'b0;
      snd_irq_q  <= 1'b0;
      ovr_q      <= 1'b0;
      ipl_n_q    <= 1'b1;
      wdog_rst_q <= 1'b0;
      wdog_cnt_q <= '0;
      pulse_q    <= 8'h00;
      vb_q       <= 3'b111;
    end else begin
      io_dout_q  <= io_dout_d;
      snd_cmd_q  <= snd_cmd_d;
      pri_q      <= pri_d;
      cc_q       <= cc_d;
      rmrd_q     <= rmrd_d;
      int_en_q   <= int_en_d;
      snd_on_q   <= snd_on_d;
      snd_irq_q  <= snd_irq_d;
      ovr_q      <= ovr_d;
      ipl_n_q    <= ipl_n_d;
      wdog_rst_q <= wdog_rst_d;
      wdog_cnt_q <= wdog_cnt_d;
      pulse_q    <= pulse_d;
      vb_q       <= {vb_q[1:0], nvblk};
    end
  end

  assign io_dout      = io_dout_q;
  assign snd_cmd      = snd_cmd_q;
  assign pri          = pri_q;
  assign coin_counter = cc_q;
  assign rmrd         = rmrd_q;
  assign int_en       = int_en_q;
  assign snd_on       = snd_on_q;
  assign snd_irq      = snd_irq_q;
  assign ipl_n        = ipl_n_q;
  assign wdog_rst     = wdog_rst_q;

endmodule

// File: tb/tb_sysio_ctrl.sv
// Self-checking bench for sysio_ctrl: directed scenarios plus randomized traffic against a
// behavioural model; honours INPUT_SYNC_EN when the design is built with it.
module tb_sysio_ctrl;

  localparam int unsigned NP   = 2;
  localparam int unsigned WB   = 4;
  localparam int unsigned WP   = 3;
  localparam int          WMAX = (1 << WB) - 1;

  logic            clk_main = 1'b0;
  logic            reset    = 1'b0;
  logic            io_we    = 1'b0;
  logic            io_re    = 1'b0;
  logic [3:0]      io_addr  = 4'h0;
  logic [7:0]      io_din   = 8'h00;
  logic [7:0]      io_dout;
  logic [8*NP-1:0] p_in     = '1;
  logic [3:0]      coin     = 4'hF;
  logic [3:0]      service  = 4'hF;
  logic [7:0]      dip1     = 8'hFF;
  logic [7:0]      dip2     = 8'hFF;
  logic [3:0]      dip3     = 4'hF;
  logic            nvblk    = 1'b1;
  logic            ipl_n, rmrd, int_en, snd_on, snd_irq, wdog_rst;
  logic            snd_ack  = 1'b0;
  logic [1:0]      coin_counter, pri;
  logic [7:0]      snd_cmd;

  always #5 clk_main = ~clk_main;

  sysio_ctrl #(
    .NUM_PLAYERS(NP),
    .WDOG_BITS  (WB),
    .WDOG_PULSE (WP)
  ) dut (
    .clk_main    (clk_main),
    .reset       (reset),
    .io_we       (io_we),
    .io_re       (io_re),
    .io_addr     (io_addr),
    .io_din      (io_din),
    .io_dout     (io_dout),
    .p_in        (p_in),
    .coin        (coin),
    .service     (service),
    .dip1        (dip1),
    .dip2        (dip2),
    .dip3        (dip3),
    .nvblk       (nvblk),
    .ipl_n       (ipl_n),
    .rmrd        (rmrd),
    .int_en      (int_en),
    .snd_on      (snd_on),
    .coin_counter(coin_counter),
    .pri         (pri),
    .snd_cmd     (snd_cmd),
    .snd_irq     (snd_irq),
    .snd_ack     (snd_ack),
    .wdog_rst    (wdog_rst)
  );

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state.
  logic [7:0] m_dout, m_snd_cmd;
  logic [1:0] m_cc, m_pri;
  logic       m_rmrd, m_int_en, m_snd_on, m_snd_irq, m_ovr, m_ipl_n, m_wdog_rst;
  int         m_wcnt, m_wleft;
  logic [7:0] nv_h;  // bit k = nvblk sampled k+1 edges ago
`ifdef INPUT_SYNC_EN
  logic [8*NP-1:0] h_p1, h_p2;
  logic [3:0]      h_c1, h_c2, h_s1, h_s2;
`endif

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dout = 8'h00; m_snd_cmd = 8'h00; m_cc = 2'b00; m_pri = 2'b00;
    m_rmrd = 1'b0; m_int_en = 1'b0; m_snd_on = 1'b0; m_snd_irq = 1'b0; m_ovr = 1'b0;
    m_ipl_n = 1'b1; m_wdog_rst = 1'b0; m_wcnt = 0; m_wleft = 0;
    nv_h = 8'hFF;
`ifdef INPUT_SYNC_EN
    h_p1 = '1; h_p2 = '1; h_c1 = '1; h_c2 = '1; h_s1 = '1; h_s2 = '1;
`endif
  endtask

  task automatic model_edge();
    logic [8*NP-1:0] pv;
    logic [3:0]      cv, sv;
    logic [7:0]      rd;
    logic            fall;
`ifdef INPUT_SYNC_EN
    pv = h_p2; cv = h_c2; sv = h_s2;
`else
    pv = p_in; cv = coin; sv = service;
`endif
    case (io_addr)
      4'd0:    rd = {sv, cv};
      4'd8:    rd = dip1;
      4'd9:    rd = dip2;
      4'd10:   rd = {4'h0, dip3};
      4'd11:   rd = {6'b0, m_ovr, m_snd_irq};
      default: rd = (io_addr >= 1 && io_addr <= NP) ? 8'(pv >> (8 * (int'(io_addr) - 1))) : 8'hFF;
    endcase
    if (io_re) m_dout = rd;

    fall = nv_h[2] && !nv_h[1];
    if (!m_int_en) m_ipl_n = 1'b1;
    else if (fall) m_ipl_n = 1'b0;

    if (m_wdog_rst) begin
      m_wleft--;
      if (m_wleft == 0) begin
        m_wdog_rst = 1'b0;
        m_wcnt     = 0;
      end
    end else if (io_we && io_addr == 4'd2) begin
      m_wcnt = 0;
    end else begin
      m_wcnt++;
      if (m_wcnt == WMAX) begin
        m_wdog_rst = 1'b1;
        m_wleft    = WP;
      end
    end

    if (io_we && io_addr == 4'd1) begin
      if (m_snd_irq && !snd_ack) m_ovr = 1'b1;
      m_snd_irq = 1'b1;
      m_snd_cmd = io_din;
    end else if (snd_ack) begin
      m_snd_irq = 1'b0;
    end

    if (io_we) begin
      case (io_addr)
        4'd0: begin
          m_rmrd = io_din[7]; m_int_en = io_din[5]; m_snd_on = io_din[3]; m_cc = io_din[1:0];
        end
        4'd3:    m_pri = io_din[3:2];
        4'd11:   m_ovr = 1'b0;
        default: ;
      endcase
    end

    nv_h = {nv_h[6:0], nvblk};
`ifdef INPUT_SYNC_EN
    h_p2 = h_p1; h_p1 = p_in;
    h_c2 = h_c1; h_c1 = coin;
    h_s2 = h_s1; h_s1 = service;
`endif
  endtask

  task automatic compare_all();
    chk("io_dout", io_dout, m_dout);
    chk("ipl_n", 8'(ipl_n), 8'(m_ipl_n));
    chk("rmrd", 8'(rmrd), 8'(m_rmrd));
    chk("int_en", 8'(int_en), 8'(m_int_en));
    chk("snd_on", 8'(snd_on), 8'(m_snd_on));
    chk("coin_counter", 8'(coin_counter), 8'(m_cc));
    chk("pri", 8'(pri), 8'(m_pri));
    chk("snd_cmd", snd_cmd, m_snd_cmd);
    chk("snd_irq", 8'(snd_irq), 8'(m_snd_irq));
    chk("wdog_rst", 8'(wdog_rst), 8'(m_wdog_rst));
  endtask

  // Caller is at a falling edge with inputs set up; returns at the next falling edge.
  task automatic step();
    @(posedge clk_main);
    model_edge();
    @(negedge clk_main);
    compare_all();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #1 compare_all();
    repeat (2) begin
      @(negedge clk_main);
      compare_all();
    end
    reset = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    io_we = 1'b1; io_addr = a; io_din = d;
    step();
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    io_re = 1'b1; io_addr = a;
    step();
    io_re = 1'b0;
  endtask

  int hi;

  initial begin
    #2 apply_reset();

    // Reset-state reads and free-running watchdog timing.
    for (int c = 1; c <= 40; c++) begin
      io_re   = (c <= 3);
      io_addr = (c == 1) ? 4'd11 : (c == 2) ? 4'd0 : 4'd12;
      step();
      io_re = 1'b0;
      if (c == 1) chk("rst_rd11", io_dout, 8'h00);
      if (c == 2) chk("rst_rd0", io_dout, 8'hFF);
      if (c == 3) begin
        chk("rst_rd12", io_dout, 8'hFF);
        chk("rst_ipl_n", 8'(ipl_n), 8'h01);
      end
      if (c == 14) chk("wd_c14", 8'(wdog_rst), 8'h00);
      if (c == 15) chk("wd_c15", 8'(wdog_rst), 8'h01);
      if (c == 17) chk("wd_c17", 8'(wdog_rst), 8'h01);
      if (c == 18) chk("wd_c18", 8'(wdog_rst), 8'h00);
      if (c == 32) chk("wd_c32", 8'(wdog_rst), 8'h00);
      if (c == 33) chk("wd_c33", 8'(wdog_rst), 8'h01);
      if (c == 36) chk("wd_c36", 8'(wdog_rst), 8'h00);
    end

    // Regular kicks keep the watchdog quiet.
    @(negedge clk_main);
    apply_reset();
    hi = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c % 10 == 0) wr(4'd2, 8'h5C);
      else step();
      if (wdog_rst) hi++;
    end
    chk("wd_kicked", 8'(hi), 8'h00);

    wr(4'd0, 8'hAB);
    wr(4'd3, 8'h0C);
    chk("ctl_rmrd", 8'(rmrd), 8'h01);
    chk("ctl_int_en", 8'(int_en), 8'h01);
    chk("ctl_snd_on", 8'(snd_on), 8'h01);
    chk("ctl_cc", 8'(coin_counter), 8'h03);
    chk("ctl_pri", 8'(pri), 8'h03);

    // Sound command overrun and clear.
    wr(4'd1, 8'h5A);
    wr(4'd1, 8'h33);
    rd(4'd11);
    chk("snd_cmd33", snd_cmd, 8'h33);
    chk("snd_irq_set", 8'(snd_irq), 8'h01);
    chk("snd_ovr_rd", io_dout, 8'h03);
    snd_ack = 1'b1;
    step();
    snd_ack = 1'b0;
    chk("snd_ack_clr", 8'(snd_irq), 8'h00);
    wr(4'd11, 8'h00);
    rd(4'd11);
    chk("snd_ovr_clr", io_dout, 8'h00);
    wr(4'd1, 8'h22);
    snd_ack = 1'b1;
    wr(4'd1, 8'h11);
    snd_ack = 1'b0;
    rd(4'd11);
    chk("snd_wr_ack", io_dout, 8'h01);
    chk("snd_cmd11", snd_cmd, 8'h11);

    // VBLANK interrupt: set on blank start, cleared by int_en=0.
    nvblk = 1'b0;
    step();
    step();
    chk("irq_lat2", 8'(ipl_n), 8'h01);
    step();
    chk("irq_lat3", 8'(ipl_n), 8'h00);
    wr(4'd0, 8'h8B);
    step();
    chk("irq_clr", 8'(ipl_n), 8'h01);
    nvblk = 1'b1;
    repeat (4) step();
    nvblk = 1'b0;
    repeat (5) step();
    chk("irq_masked", 8'(ipl_n), 8'h01);
    nvblk = 1'b1;

    // Player input mux.
    p_in = 16'h7EFD;
    repeat (2) step();
    rd(4'd1);
    chk("p1", io_dout, 8'hFD);
    rd(4'd2);
    chk("p2", io_dout, 8'h7E);
    rd(4'd3);
    chk("p3_absent", io_dout, 8'hFF);
    p_in = 16'h7E11;
    rd(4'd1);
`ifdef INPUT_SYNC_EN
    chk("p1_sync_old", io_dout, 8'hFD);
`else
    chk("p1_raw_new", io_dout, 8'h11);
`endif
    step();
    rd(4'd1);
    chk("p1_new", io_dout, 8'h11);

    // Reset in the middle of a pending command and an active watchdog pulse.
    wr(4'd1, 8'h44);
    for (int i = 0; i < 40 && !wdog_rst; i++) step();
    chk("mid_wd_pre", 8'(wdog_rst), 8'h01);
    chk("mid_irq_pre", 8'(snd_irq), 8'h01);
    apply_reset();
    chk("mid_wd_post", 8'(wdog_rst), 8'h00);
    chk("mid_irq_post", 8'(snd_irq), 8'h00);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      io_we   = ($urandom_range(0, 3) == 0);
      io_re   = ($urandom_range(0, 2) == 0);
      io_addr = 4'($urandom_range(0, 15));
      io_din  = 8'($urandom);
      snd_ack = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) nvblk = ~nvblk;
      if ($urandom_range(0, 3) == 0) p_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) coin = 4'($urandom);
      if ($urandom_range(0, 3) == 0) service = 4'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        dip1 = 8'($urandom); dip2 = 8'($urandom); dip3 = 4'($urandom);
      end
      step();
      if ($urandom_range(0, 499) == 0) apply_reset();
    end
    io_we = 1'b0; io_re = 1'b0; snd_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
